// File: rtl/ps2_matrix_decoder.sv
// rtl/ps2_matrix_decoder.sv - PS/2 set-2 scancode to multi-key matrix decoder
module ps2_matrix_decoder #(
  parameter int COLS      = 16,
  parameter int ROWS      = 4,
  parameter int COL_BITS  = 4,
  parameter int SHIFT_COL = 1,
  parameter int SHIFT_ROW = 1,
  parameter int ROW_BITS  = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int CNT_BITS  = $clog2(COLS * ROWS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          rxData,
  input  logic                rxValid,
  input  logic                rxError,
  output logic                mapReq,
  output logic [8:0]          mapCode,
  input  logic                mapHit,
  input  logic [COL_BITS-1:0] mapCol,
  input  logic [ROW_BITS-1:0] mapRow,
  input  logic [COL_BITS-1:0] address,
  output logic [ROWS-1:0]     keybits,
  output logic [CNT_BITS-1:0] heldCount,
  output logic                shift,
  output logic                ctrl,
  output logic                alt,
  output logic                softReset,
  output logic                overrun
);

  typedef enum logic [2:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0, PAUSE, LOOKUP, APPLY} state_t;

  state_t                    state;
  state_t                    state_next;
  logic [COLS-1:0][ROWS-1:0] matrix;
  logic                      shift_l;
  logic                      shift_r;
  logic                      brk_pending;
  logic [2:0]                pause_cnt;
  logic                      clear_all;
  logic                      set_overrun;
  logic                      final_code;
  logic                      pause_load;
  logic                      is_ext;
  logic                      is_brk;
  logic                      is_mod;
  logic                      sel_hit;
  logic                      sel_bit;

  assign shift = shift_l | shift_r;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Byte parser: prefix tracking, Pause skipping and the two-cycle lookup sequence
  always_comb begin
    state_next  = state;
    clear_all   = 1'b0;
    set_overrun = 1'b0;
    final_code  = 1'b0;
    pause_load  = 1'b0;
    is_ext      = (state == GOT_E0) || (state == GOT_E0F0);
    is_brk      = (state == GOT_F0) || (state == GOT_E0F0);
    is_mod      = rxData inside {8'h12, 8'h59, 8'h14, 8'h11};
    if (rxError) begin
      clear_all  = 1'b1;
      state_next = IDLE;
    end else begin
      if (rxValid) begin
        case (state)
          IDLE: begin
            case (rxData)
              8'hE0:        state_next = GOT_E0;
              8'hF0:        state_next = GOT_F0;
              8'hE1: begin
                state_next = PAUSE;
                pause_load = 1'b1;
              end
              8'hAA, 8'hFC: clear_all = 1'b1;
              8'h00, 8'hFF: begin
                clear_all   = 1'b1;
                set_overrun = 1'b1;
              end
              default:      final_code = 1'b1;
            endcase
          end
          GOT_E0: begin
            if (rxData == 8'hF0) state_next = GOT_E0F0;
            else                 final_code = 1'b1;
          end
          GOT_F0, GOT_E0F0: final_code = 1'b1;
          PAUSE:            if (pause_cnt <= 3'd1) state_next = IDLE;
          LOOKUP, APPLY:    set_overrun = 1'b1;
          default:          state_next = IDLE;
        endcase
        if (final_code) state_next = is_mod ? IDLE : LOOKUP;
      end
      // The lookup handshake runs on regardless of incoming bytes, which are dropped
      if (state == LOOKUP)     state_next = APPLY;
      else if (state == APPLY) state_next = IDLE;
    end
  end

  // Select the matrix bit addressed by the map response; out-of-range answers never match
  always_comb begin
    sel_hit = 1'b0;
    sel_bit = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (mapCol == COL_BITS'(c) && mapRow == ROW_BITS'(r)) begin
          sel_hit = mapHit;
          sel_bit = matrix[c][r];
        end
      end
    end
  end

  // Matrix, modifiers, lookup request and sticky overrun
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      matrix      <= '0;
      heldCount   <= '0;
      shift_l     <= 1'b0;
      shift_r     <= 1'b0;
      ctrl        <= 1'b0;
      alt         <= 1'b0;
      softReset   <= 1'b0;
      overrun     <= 1'b0;
      mapReq      <= 1'b0;
      mapCode     <= '0;
      brk_pending <= 1'b0;
      pause_cnt   <= '0;
    end else begin
      mapReq <= 1'b0;
      if (set_overrun) overrun <= 1'b1;
      if (pause_load) pause_cnt <= 3'd7;
      else if (state == PAUSE && rxValid && !rxError) pause_cnt <= pause_cnt - 3'd1;
      if (clear_all) begin
        matrix    <= '0;
        heldCount <= '0;
        shift_l   <= 1'b0;
        shift_r   <= 1'b0;
        ctrl      <= 1'b0;
        alt       <= 1'b0;
        softReset <= 1'b0;
      end else begin
        if (final_code) begin
          if (!is_mod) begin
            mapReq      <= 1'b1;
            mapCode     <= {is_ext, rxData};
            brk_pending <= is_brk;
          end else if (!is_ext && rxData == 8'h12) begin
            shift_l <= !is_brk;
          end else if (!is_ext && rxData == 8'h59) begin
            shift_r <= !is_brk;
          end else if (rxData == 8'h14) begin
            ctrl <= !is_brk;
          end else if (rxData == 8'h11) begin
            alt <= !is_brk;
          end
          // E0 12 / E0 59 are fake shifts and fall through untouched
          if (is_ext && rxData == 8'h71) begin
            if (is_brk)                   softReset <= 1'b0;
            else if (ctrl && alt && !shift) softReset <= 1'b1;
          end
        end
        if (state == APPLY && sel_hit) begin
          if (!brk_pending && !sel_bit && heldCount != CNT_BITS'(COLS * ROWS)) begin
            matrix[mapCol][mapRow] <= 1'b1;
            heldCount              <= heldCount + CNT_BITS'(1);
          end else if (brk_pending && sel_bit && heldCount != '0) begin
            matrix[mapCol][mapRow] <= 1'b0;
            heldCount              <= heldCount - CNT_BITS'(1);
          end
        end
      end
    end
  end

  // Column read-out with shift overlaid on its fixed position
  always_comb begin
    keybits = '0;
    for (int c = 0; c < COLS; c++) begin
      if (address == COL_BITS'(c)) keybits = matrix[c];
    end
    if (shift && address == COL_BITS'(SHIFT_COL)) keybits[SHIFT_ROW] = 1'b1;
  end

endmodule

// File: tb/tb_ps2_matrix_decoder.sv
// tb/tb_ps2_matrix_decoder.sv - self-checking bench for ps2_matrix_decoder
module tb_ps2_matrix_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rxData = 8'h00;
  logic       rxValid = 1'b0;
  logic       rxError = 1'b0;
  logic       mapReq;
  logic [8:0] mapCode;
  logic       mapHit = 1'b0;
  logic [3:0] mapCol = 4'd0;
  logic [1:0] mapRow = 2'd0;
  logic [3:0] address = 4'd0;
  logic [3:0] keybits;
  logic [6:0] heldCount;
  logic       shift, ctrl, alt, softReset, overrun;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;
  int last   = 0;
  int n_req  = 0;
  int r0;
  bit cmp_en = 0;
  bit scan   = 0;

  // Key model
  logic [3:0] m_mat [16];
  bit m_sl, m_sr, m_ctrl, m_alt, m_soft, m_ovr, m_e0, m_f0;
  int m_pause;
  int m_lk;

  // Map responder
  bit         pend = 0;
  logic [8:0] pend_code = 9'h000;
  logic [6:0] resp;

  always #5 clk = ~clk;

  ps2_matrix_decoder dut (
    .clk(clk), .reset(reset), .rxData(rxData), .rxValid(rxValid), .rxError(rxError),
    .mapReq(mapReq), .mapCode(mapCode), .mapHit(mapHit), .mapCol(mapCol), .mapRow(mapRow),
    .address(address), .keybits(keybits), .heldCount(heldCount), .shift(shift), .ctrl(ctrl),
    .alt(alt), .softReset(softReset), .overrun(overrun)
  );

  function automatic logic [6:0] map_lookup(input logic [8:0] code);
    case (code)
      9'h01C:  return {1'b1, 4'd2, 2'd1};
      9'h01B:  return {1'b1, 4'd3, 2'd1};
      9'h023:  return {1'b1, 4'd5, 2'd3};
      9'h01D:  return {1'b1, 4'd0, 2'd2};
      9'h175:  return {1'b1, 4'd15, 2'd0};
      9'h15A:  return {1'b1, 4'd9, 2'd2};
      default: return {1'b0, 4'd7, 2'd3};
    endcase
  endfunction

  always @(posedge clk) cyc++;
  always @(negedge clk) if (mapReq) n_req++;

  always @(posedge clk) begin
    #1;
    resp   = map_lookup(pend_code);
    mapHit = pend && resp[6];
    mapCol = resp[5:2];
    mapRow = resp[1:0];
    pend      = mapReq;
    pend_code = mapCode;
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int m_count();
    int n = 0;
    foreach (m_mat[i]) n += $countones(m_mat[i]);
    return n;
  endfunction

  function automatic logic [3:0] exp_kb(input logic [3:0] a);
    return m_mat[a] | (((m_sl || m_sr) && a == 4'd1) ? 4'b0010 : 4'b0000);
  endfunction

  task automatic model_clear();
    foreach (m_mat[i]) m_mat[i] = 4'h0;
    m_sl = 0; m_sr = 0; m_ctrl = 0; m_alt = 0; m_soft = 0;
    m_e0 = 0; m_f0 = 0; m_pause = 0; m_lk = -100;
  endtask

  task automatic model_final(input logic [7:0] b, input int cb);
    bit ext, brk;
    logic [6:0] lk;
    ext = m_e0; brk = m_f0; m_e0 = 0; m_f0 = 0;
    if (b inside {8'h12, 8'h59, 8'h14, 8'h11}) begin
      if (!ext && b == 8'h12)      m_sl = !brk;
      else if (!ext && b == 8'h59) m_sr = !brk;
      else if (b == 8'h14)         m_ctrl = !brk;
      else if (b == 8'h11)         m_alt = !brk;
    end else begin
      m_lk = cb;
      lk = map_lookup({ext, b});
      if (lk[6]) m_mat[lk[5:2]][lk[1:0]] = !brk;
    end
    if (ext && b == 8'h71) begin
      if (brk) m_soft = 0;
      else if (m_ctrl && m_alt && !(m_sl || m_sr)) m_soft = 1;
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input int cb);
    if (cb - m_lk <= 2) begin
      m_ovr = 1;
    end else if (m_pause > 0) begin
      m_pause--;
    end else if (!m_e0 && !m_f0) begin
      if (b == 8'hE0)                   m_e0 = 1;
      else if (b == 8'hF0)              m_f0 = 1;
      else if (b == 8'hE1)              m_pause = 7;
      else if (b == 8'hAA || b == 8'hFC) model_clear();
      else if (b == 8'h00 || b == 8'hFF) begin model_clear(); m_ovr = 1; end
      else                              model_final(b, cb);
    end else if (m_e0 && !m_f0 && b == 8'hF0) begin
      m_f0 = 1;
    end else begin
      model_final(b, cb);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (scan) address = address + 4'd1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rxData = b; rxValid = 1'b1;
    @(posedge clk); #1;
    rxValid = 1'b0;
    last = cyc;
    model_byte(b, cyc);
  endtask

  task automatic sendk(input logic [7:0] b);
    send(b);
    idle(4);
  endtask

  // Every settled cycle: all observable state against the model
  always @(negedge clk) begin
    if (cmp_en && reset && (cyc - last >= 2)) begin
      check("cmp_keybits", keybits, exp_kb(address));
      check("cmp_heldCount", heldCount, m_count());
      check("cmp_shift", shift, m_sl || m_sr);
      check("cmp_ctrl", ctrl, m_ctrl);
      check("cmp_alt", alt, m_alt);
      check("cmp_softReset", softReset, m_soft);
      check("cmp_overrun", overrun, m_ovr);
    end
  end

  initial begin
    model_clear(); m_ovr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_heldCount", heldCount, 0);
    check("rst_mapReq", mapReq, 0);
    check("rst_mapCode", mapCode, 0);
    check("rst_overrun", overrun, 0);
    check("rst_keybits", keybits, 0);
    @(posedge clk); #1;
    reset = 1'b1; last = cyc; cmp_en = 1;

    // 1: two keys held
    sendk(8'h1C); sendk(8'h1B);
    address = 4'd2; @(negedge clk);
    check("t1_col2", keybits, 4'b0010);
    check("t1_held", heldCount, 2);
    address = 4'd3; @(negedge clk);
    check("t1_col3", keybits, 4'b0010);
    sendk(8'hE0); sendk(8'h75);
    address = 4'd15; @(negedge clk);
    check("t1_ext_col15", keybits, 4'b0001);
    check("t1_ext_held", heldCount, 3);
    sendk(8'hE0); sendk(8'hF0); sendk(8'h75);
    sendk(8'h7E);
    sendk(8'hE0); sendk(8'h12);
    check("t1_fake_shift", shift, 0);
    check("t1_after_miss", heldCount, 2);

    // 2: break with exact two-cycle latency
    address = 4'd2;
    send(8'hF0); idle(3);
    send(8'h1C);
    @(negedge clk); check("t2_lat0", keybits, 4'b0010);
    @(posedge clk); #1; @(negedge clk); check("t2_lat1", keybits, 4'b0010);
    @(posedge clk); #1; @(negedge clk); check("t2_lat2", keybits, 4'b0000);
    check("t2_held", heldCount, 1);
    address = 4'd3; @(negedge clk); check("t2_col3", keybits, 4'b0010);

    // 3: shift overlay and typematic repeats
    sendk(8'hF0); sendk(8'h1B);
    sendk(8'h12);
    address = 4'd1; @(negedge clk);
    check("t3_shift_col", keybits, 4'b0010);
    sendk(8'h1C); sendk(8'h1C); sendk(8'h1C);
    check("t3_typematic", heldCount, 1);
    sendk(8'hF0); sendk(8'h12);

    // 4: Ctrl+Alt+Del
    r0 = n_req;
    sendk(8'h14); sendk(8'h11);
    check("t4_mod_no_req", n_req - r0, 0);
    sendk(8'hE0); sendk(8'h71);
    check("t4_soft_set", softReset, 1);
    sendk(8'hE0); sendk(8'hF0); sendk(8'h71);
    check("t4_soft_clr", softReset, 0);
    sendk(8'h12); sendk(8'hE0); sendk(8'h71);
    check("t4_soft_shift", softReset, 0);
    sendk(8'hF0); sendk(8'h12); sendk(8'hF0); sendk(8'h14); sendk(8'hF0); sendk(8'h11);

    // 5: Pause sequence is skipped
    scan = 1;
    r0 = n_req;
    sendk(8'hE1); sendk(8'h14); sendk(8'h77); sendk(8'hE1);
    sendk(8'hF0); sendk(8'h14); sendk(8'hF0); sendk(8'h77);
    check("t5_ctrl", ctrl, 0);
    check("t5_no_req", n_req - r0, 0);
    sendk(8'h1D);
    scan = 0;
    address = 4'd0; @(negedge clk);
    check("t5_idle_after", keybits, 4'b0100);
    check("t5_held", heldCount, 2);

    // 6: error, overrun, reset mid-sequence, keyboard overflow
    sendk(8'h12);
    rxError = 1'b1; @(posedge clk); #1; rxError = 1'b0;
    model_clear(); last = cyc;
    @(negedge clk);
    check("t6_err_held", heldCount, 0);
    check("t6_err_shift", shift, 0);
    check("t6_err_kb", keybits, 4'b0000);
    send(8'h1C); send(8'h1B); idle(4);
    check("t6_ovr", overrun, 1);
    check("t6_ovr_held", heldCount, 1);
    address = 4'd3; @(negedge clk);
    check("t6_dropped", keybits, 4'b0000);
    send(8'hE0);
    @(negedge clk); reset = 1'b0;
    model_clear(); m_ovr = 0;
    @(negedge clk);
    check("t6_rst_ovr", overrun, 0);
    check("t6_rst_held", heldCount, 0);
    @(posedge clk); #1; reset = 1'b1; last = cyc;
    sendk(8'h1C);
    address = 4'd2; @(negedge clk);
    check("t6_rst_idle", keybits, 4'b0010);
    sendk(8'hAA);
    check("t6_bat", heldCount, 0);
    sendk(8'h1C); sendk(8'hFF);
    check("t6_ff_held", heldCount, 0);
    check("t6_ff_ovr", overrun, 1);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
